// File: rtl/ofdm_frame_seq.sv
// OFDM TX frame sequencer: short/long preamble from ROM, then CP-prefixed data symbols
// drained from two ping-pong input buffers, with an optional zero gap after each frame.
module ofdm_frame_seq #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned NFFT_LOG2 = 8,
    parameter int unsigned CP_LEN    = 8,
    parameter int unsigned SHORT_LEN = 256,
    parameter int unsigned LONG_LEN  = 256,
    parameter int unsigned GAP_LEN   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 begin_tx,
    input  logic [7:0]           frame_size,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data_i,
    output logic [DATA_SIZE-1:0] out_data_q,
    output logic [15:0]          pre_addr,
    output logic                 pre_sel,
    input  logic [DATA_SIZE-1:0] pre_data_i,
    input  logic [DATA_SIZE-1:0] pre_data_q,
    output logic                 done,
    output logic                 err_underrun,
    output logic [2:0]           o_state
);

    localparam int unsigned NFFT    = 1 << NFFT_LOG2;
    localparam int unsigned SYM_LEN = NFFT + CP_LEN;
    localparam int unsigned CW      = NFFT_LOG2 + 1;
    localparam int unsigned AW      = NFFT_LOG2;

    localparam logic [15:0]   SHORT_LAST = 16'(SHORT_LEN - 1);
    localparam logic [15:0]   LONG_LAST  = 16'(LONG_LEN - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_LEN - 1);
    localparam logic [CW-1:0] SYM_LAST   = CW'(SYM_LEN - 1);
    localparam logic [CW-1:0] CP_W       = CW'(CP_LEN);
    localparam logic [CW-1:0] CP_BASE    = CW'(NFFT - CP_LEN);
    localparam logic [AW-1:0] WR_LAST    = AW'(NFFT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHORT = 3'd1;
    localparam logic [2:0] S_LONG  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]           r_state,     w_state_nx;
    logic [15:0]          r_pre_addr,  w_pre_addr_nx;
    logic                 r_pre_sel,   w_pre_sel_nx;
    logic [7:0]           r_fs,        w_fs_nx;
    logic [8:0]           r_sym,       w_sym_nx;
    logic [8:0]           r_loaded,    w_loaded_nx;
    logic [CW-1:0]        r_rd_cnt,    w_rd_cnt_nx;
    logic                 r_rd_buf,    w_rd_buf_nx;
    logic                 r_rel_pend,  w_rel_pend_nx;
    logic                 r_rel_buf,   w_rel_buf_nx;
    logic [15:0]          r_gap_cnt,   w_gap_cnt_nx;
    logic [1:0]           r_full,      w_full_nx;
    logic                 r_wr_buf,    w_wr_buf_nx;
    logic [AW-1:0]        r_wr_addr,   w_wr_addr_nx;
    logic                 r_in_ready,  w_in_ready_nx;
    logic                 r_out_valid, w_out_valid_nx;
    logic [DATA_SIZE-1:0] r_out_i,     w_out_i_nx;
    logic [DATA_SIZE-1:0] r_out_q,     w_out_q_nx;
    logic                 r_done,      w_done_nx;
    logic                 r_err,       w_err_nx;

    logic                 w_wr;
    logic [AW-1:0]        w_rd_addr;

    logic [DATA_SIZE-1:0] r_mem_i [0:1][0:NFFT-1];
    logic [DATA_SIZE-1:0] r_mem_q [0:1][0:NFFT-1];

    assign w_wr = in_valid && r_in_ready;

    // CP samples come from the tail of the symbol, then the whole symbol in order
    always_comb begin
        if (r_rd_cnt < CP_W) begin
            w_rd_addr = AW'(r_rd_cnt + CP_BASE);
        end else begin
            w_rd_addr = AW'(r_rd_cnt - CP_W);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_i[r_wr_buf][r_wr_addr] <= in_data_i;
            r_mem_q[r_wr_buf][r_wr_addr] <= in_data_q;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pre_addr_nx  = r_pre_addr;
        w_pre_sel_nx   = r_pre_sel;
        w_fs_nx        = r_fs;
        w_sym_nx       = r_sym;
        w_loaded_nx    = r_loaded;
        w_rd_cnt_nx    = r_rd_cnt;
        w_rd_buf_nx    = r_rd_buf;
        w_rel_pend_nx  = r_rel_pend;
        w_rel_buf_nx   = r_rel_buf;
        w_gap_cnt_nx   = r_gap_cnt;
        w_full_nx      = r_full;
        w_wr_buf_nx    = r_wr_buf;
        w_wr_addr_nx   = r_wr_addr;
        w_out_valid_nx = r_out_valid;
        w_out_i_nx     = r_out_i;
        w_out_q_nx     = r_out_q;
        w_done_nx      = r_done;
        w_err_nx       = r_err;

        // Input side runs regardless of out_ready
        if (w_wr) begin
            w_wr_addr_nx = r_wr_addr + AW'(1);
            if (r_wr_addr == WR_LAST) begin
                w_full_nx[r_wr_buf] = 1'b1;
                w_wr_buf_nx         = ~r_wr_buf;
                w_loaded_nx         = r_loaded + 9'd1;
            end
        end

        if (out_ready) begin
            w_out_valid_nx = 1'b0;
            w_out_i_nx     = '0;
            w_out_q_nx     = '0;
            w_done_nx      = 1'b0;
            w_err_nx       = 1'b0;

            // Buffer is freed once its last sample has been presented on the output
            if (r_rel_pend) begin
                w_full_nx[r_rel_buf] = 1'b0;
                w_rel_pend_nx        = 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (begin_tx) begin
                        w_state_nx    = S_SHORT;
                        w_fs_nx       = frame_size;
                        w_sym_nx      = '0;
                        w_loaded_nx   = '0;
                        w_rd_cnt_nx   = '0;
                        w_gap_cnt_nx  = '0;
                        w_pre_addr_nx = '0;
                        w_pre_sel_nx  = 1'b0;
                    end
                end
                S_SHORT: begin
                    w_out_valid_nx = 1'b1;
                    w_out_i_nx     = pre_data_i;
                    w_out_q_nx     = pre_data_q;
                    if (r_pre_addr == SHORT_LAST) begin
                        w_state_nx    = S_LONG;
                        w_pre_addr_nx = '0;
                        w_pre_sel_nx  = 1'b1;
                    end else begin
                        w_pre_addr_nx = r_pre_addr + 16'd1;
                    end
                end
                S_LONG: begin
                    w_out_valid_nx = 1'b1;
                    w_out_i_nx     = pre_data_i;
                    w_out_q_nx     = pre_data_q;
                    if (r_pre_addr == LONG_LAST) begin
                        w_state_nx    = S_DATA;
                        w_pre_addr_nx = '0;
                        w_pre_sel_nx  = 1'b0;
                    end else begin
                        w_pre_addr_nx = r_pre_addr + 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_full[r_rd_buf]) begin
                        w_out_valid_nx = 1'b1;
                        w_out_i_nx     = r_mem_i[r_rd_buf][w_rd_addr];
                        w_out_q_nx     = r_mem_q[r_rd_buf][w_rd_addr];
                        if (r_rd_cnt == SYM_LAST) begin
                            w_rd_cnt_nx   = '0;
                            w_rd_buf_nx   = ~r_rd_buf;
                            w_rel_pend_nx = 1'b1;
                            w_rel_buf_nx  = r_rd_buf;
                            w_sym_nx      = r_sym + 9'd1;
                            if (r_sym == {1'b0, r_fs}) begin
                                w_done_nx    = 1'b1;
                                w_gap_cnt_nx = '0;
                                w_state_nx   = (GAP_LEN > 0) ? S_GAP : S_IDLE;
                            end
                        end else begin
                            w_rd_cnt_nx = r_rd_cnt + CW'(1);
                        end
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_gap_cnt_nx = r_gap_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        // Ready is computed from next-cycle state so a filling write can never overrun
        w_in_ready_nx = (w_state_nx != S_IDLE) && !(&w_full_nx)
                        && (w_loaded_nx < ({1'b0, w_fs_nx} + 9'd1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pre_addr  <= '0;
            r_pre_sel   <= 1'b0;
            r_fs        <= '0;
            r_sym       <= '0;
            r_loaded    <= '0;
            r_rd_cnt    <= '0;
            r_rd_buf    <= 1'b0;
            r_rel_pend  <= 1'b0;
            r_rel_buf   <= 1'b0;
            r_gap_cnt   <= '0;
            r_full      <= '0;
            r_wr_buf    <= 1'b0;
            r_wr_addr   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pre_addr  <= w_pre_addr_nx;
            r_pre_sel   <= w_pre_sel_nx;
            r_fs        <= w_fs_nx;
            r_sym       <= w_sym_nx;
            r_loaded    <= w_loaded_nx;
            r_rd_cnt    <= w_rd_cnt_nx;
            r_rd_buf    <= w_rd_buf_nx;
            r_rel_pend  <= w_rel_pend_nx;
            r_rel_buf   <= w_rel_buf_nx;
            r_gap_cnt   <= w_gap_cnt_nx;
            r_full      <= w_full_nx;
            r_wr_buf    <= w_wr_buf_nx;
            r_wr_addr   <= w_wr_addr_nx;
            r_in_ready  <= w_in_ready_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_i     <= w_out_i_nx;
            r_out_q     <= w_out_q_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data_i   = r_out_i;
    assign out_data_q   = r_out_q;
    assign pre_addr     = r_pre_addr;
    assign pre_sel      = r_pre_sel;
    assign done         = r_done;
    assign err_underrun = r_err;
    assign o_state      = r_state;

endmodule

// File: doc/ofdm_frame_seq.md
OFDM_FRAME_SEQ -- requirements
Module: ofdm_frame_seq

Interface
REQ-001 Parameter DATA_SIZE, 16, sample width per I/Q component.
REQ-002 Parameter NFFT_LOG2, 8, log2 of symbol length NFFT.
REQ-003 Parameter CP_LEN, 8, cyclic prefix length; legal range 1..NFFT-1.
REQ-004 Parameter SHORT_LEN, 256, short preamble length in samples; legal range >=1.
REQ-005 Parameter LONG_LEN, 256, long preamble length in samples; legal range >=1.
REQ-006 Parameter GAP_LEN, 0, zero-sample gap after each frame.
REQ-007 Ports, one per entry (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- begin_tx, in, 1, frame start request.
- frame_size, in, 8, number of data symbols; the frame carries frame_size+1 symbols (FCH included).
- in_valid / in_ready, in / out, 1 each, symbol-sample handshake.
- in_data_i / in_data_q, in, DATA_SIZE each, frequency-to-time (post-IFFT) samples.
- out_ready, in, 1, downstream enable; the block advances only while high.
- out_valid, out, 1, output sample valid.
- out_data_i / out_data_q, out, DATA_SIZE each, TX samples.
- pre_addr, out, 16, preamble ROM address.
- pre_sel, out, 1, preamble select: 0 = short, 1 = long.
- pre_data_i / pre_data_q, in, DATA_SIZE each, ROM data, combinational from pre_addr/pre_sel.
- done, out, 1, end-of-frame pulse.
- err_underrun, out, 1, underrun pulse.
- o_state, out, 3, current state.

Function
REQ-008 States: IDLE=0, SHORT=1, LONG=2, DATA=3, GAP=4; o_state equals the current state.
REQ-009 All state, counter and output updates occur only in cycles with out_ready=1; when out_ready=0 every register holds, except the input-side write logic.
REQ-010 Transitions:
- IDLE->SHORT on begin_tx; frame_size is latched on the same edge.
- begin_tx is ignored outside IDLE.
REQ-011 SHORT: pre_sel=0, pre_addr counts 0..SHORT_LEN-1, then -> LONG; LONG: pre_sel=1, pre_addr counts 0..LONG_LEN-1, then -> DATA.
REQ-012 Output register: the sample selected in cycle t appears on out_data with out_valid=1 in the next advancing cycle (1-cycle latency); out_data=0 whenever out_valid=0.
REQ-013 Input buffering:
- Two NFFT-deep ping-pong buffers, each with a full flag.
- A sample is written when in_valid and in_ready are both 1, filling addresses 0..NFFT-1 in order.
- A buffer's full flag sets on its NFFT-th write.
REQ-014 in_ready=1 iff state!=IDLE, a non-full buffer exists, and symbols loaded this frame < frame_size+1.
REQ-015 DATA: each symbol from the oldest full buffer emits NFFT+CP_LEN samples:
- first buffer addresses NFFT-CP_LEN..NFFT-1 (the CP);
- then addresses 0..NFFT-1.
REQ-016 After a symbol's last sample, its buffer full flag clears in the same cycle, so that buffer is writable the next cycle; a simultaneous write and release on different buffers are both honoured.
REQ-017 Underrun: in DATA at a symbol boundary with no full buffer:
- out_valid=0 and err_underrun pulses 1 cycle;
- the pulse repeats each advancing cycle while starved;
- the symbol starts on the first cycle a buffer becomes full.
REQ-018 Symbol counter counts emitted symbols. After symbol frame_size+1 completes:
- done pulses 1 cycle, coincident with out_valid for the last sample;
- state -> GAP if GAP_LEN>0, else -> IDLE.
REQ-019 GAP: out_valid=0 for GAP_LEN advancing cycles, then -> IDLE.
REQ-020 frame_size=0 is legal: one FCH symbol is sent.
REQ-021 Frame length in out_valid samples = SHORT_LEN + LONG_LEN + (frame_size+1)*(NFFT+CP_LEN), excluding underrun bubbles.

Reset
REQ-022 reset_n=0 asynchronously forces:
- state=IDLE and all counters=0;
- both full flags cleared;
- out_valid=0, out_data=0, done=0, err_underrun=0, in_ready=0, pre_addr=0, pre_sel=0.
Buffer contents are don't-care.
REQ-023 Reset mid-frame abandons the frame; there is no done pulse, and the next begin_tx after release starts a clean frame.

Verification (NFFT_LOG2=3, CP_LEN=2, SHORT_LEN=4, LONG_LEN=4, GAP_LEN=2, out_ready=1 unless noted)
REQ-024 begin_tx with frame_size=1, input samples 1..16 streamed -> outputs are:
- 4 short ROM samples, then 4 long ROM samples;
- symbol 1 = 7,8,1..8; symbol 2 = 15,16,9..16;
- done coincides with output 16, then 2 zero cycles, then o_state=0.
REQ-025 Input withheld in DATA for 5 cycles -> out_valid=0 and err_underrun=1 in each of those 5 cycles; the symbol resumes intact once 8 samples arrive.
REQ-026 out_ready toggled 1,0 throughout REQ-024 -> identical output sequence at half rate; no sample duplicated or dropped.
REQ-027 Both buffers full (16 samples accepted) -> in_ready=0 until the first symbol's 10th output sample; in_ready=1 on the next cycle.
REQ-028 reset_n low during symbol 2 -> all outputs 0 immediately; a new begin_tx yields a complete REQ-024 sequence.
REQ-029 begin_tx pulsed during LONG, and frame_size changed mid-frame -> no effect on the current frame.
